// File: rtl/taxi_eth_phy_10g_tx_gbx_if.sv
// Interface between the 10G PHY TX, the 64b/66b TX gearbox and the SERDES.
// The master is the PHY TX side and the slave is the gearbox.
interface taxi_eth_phy_10g_tx_gbx_if #(
  parameter int DATA_W = 64,
  parameter int HDR_W  = 2
);

  logic [DATA_W-1:0] in_tx_data;
  logic [HDR_W-1:0]  in_tx_hdr;
  logic              in_tx_valid;
  logic              tx_gbx_req_stall;
  logic              tx_gbx_req_sync;
  logic [DATA_W-1:0] serdes_tx_data;
  logic              serdes_tx_data_valid;
  logic [5:0]        gbx_seq;
  logic              gbx_err;

  modport master (
    output in_tx_data,
    output in_tx_hdr,
    output in_tx_valid,
    input  tx_gbx_req_stall,
    input  tx_gbx_req_sync,
    input  serdes_tx_data,
    input  serdes_tx_data_valid,
    input  gbx_seq,
    input  gbx_err
  );

  modport slave (
    input  in_tx_data,
    input  in_tx_hdr,
    input  in_tx_valid,
    output tx_gbx_req_stall,
    output tx_gbx_req_sync,
    output serdes_tx_data,
    output serdes_tx_data_valid,
    output gbx_seq,
    output gbx_err
  );

endinterface

// File: rtl/taxi_eth_phy_10g_tx_gbx.sv
// 64b/66b TX gearbox: packs one 66-bit block per cycle into a gapless 64-bit
// SERDES word stream, using one idle input slot every 33 cycles to drain the residue.
module taxi_eth_phy_10g_tx_gbx #(
  parameter int DATA_W = 64,
  parameter int HDR_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  taxi_eth_phy_10g_tx_gbx_if.slave   gbx
);

  localparam int         BLK_W     = DATA_W + HDR_W;
  localparam int         PACK_W    = 2 * DATA_W;
  localparam logic [5:0] SEQ_STALL = 6'd31;
  localparam logic [5:0] SEQ_LAST  = 6'd32;

  if (DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "taxi_eth_phy_10g_tx_gbx: DATA_W must be 64");
  end
  if (HDR_W != 2) begin : g_bad_hdr_w
    $fatal(1, "taxi_eth_phy_10g_tx_gbx: HDR_W must be 2");
  end

  logic [5:0]        seq_q, seq_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [BLK_W-1:0]  blk;
  logic [6:0]        resLen;
  logic [PACK_W-1:0] pack;

  // Residue bits above L are always zero, so OR-ing the shifted block over it
  // forms {block, R[L-1:0]} without an explicit mask.
  always_comb begin
    blk    = {gbx.in_tx_data, gbx.in_tx_hdr};
    resLen = {seq_q, 1'b0};
    pack   = ({{(PACK_W-BLK_W){1'b0}}, blk} << resLen) | {{(PACK_W-DATA_W){1'b0}}, res_q};
  end

  always_comb begin
    seq_d   = seq_q;
    res_d   = res_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (seq_q == SEQ_LAST) begin
      // Stall slot: flush the full 64-bit residue; any block offered is dropped.
      word_d  = res_q;
      valid_d = 1'b1;
      res_d   = '0;
      seq_d   = '0;
      err_d   = gbx.in_tx_valid;
    end else if (gbx.in_tx_valid) begin
      word_d  = pack[DATA_W-1:0];
      res_d   = pack[PACK_W-1:DATA_W];
      valid_d = 1'b1;
      seq_d   = seq_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q   <= '0;
      res_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      res_q   <= res_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign gbx.serdes_tx_data       = word_q;
  assign gbx.serdes_tx_data_valid = valid_q;
  assign gbx.gbx_err              = err_q;
  assign gbx.gbx_seq              = seq_q;
  assign gbx.tx_gbx_req_stall     = (seq_q == SEQ_STALL);
  assign gbx.tx_gbx_req_sync      = (seq_q == SEQ_LAST);

endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_gbx.sv
// Directed self-checking bench for the 64b/66b TX gearbox, backed by a
// bit-serial reference model of the transmitted stream.
module tb_taxi_eth_phy_10g_tx_gbx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  taxi_eth_phy_10g_tx_gbx_if #(.DATA_W(64), .HDR_W(2)) gbxIf ();

  taxi_eth_phy_10g_tx_gbx #(.DATA_W(64), .HDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .gbx (gbxIf.slave)
  );

  int checkCount = 0;
  int errorCount = 0;

  logic        modelBits[$];
  int          modelSeq;
  logic [63:0] modelWord;
  logic        modelValid;
  logic        modelErr;

  logic [63:0] lastWord;
  logic        lastValid;

  bit          recordOn = 1'b0;
  logic [65:0] sentBlocks[$];
  logic        rxBits[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check the seq-derived outputs, step the
  // reference model, then check the registered outputs after the edge.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [1:0] h);
    logic [65:0] blkBits;
    gbxIf.in_tx_valid = v;
    gbxIf.in_tx_data  = d;
    gbxIf.in_tx_hdr   = h;
    blkBits = {d, h};
    checkOutput("seq", 64'(gbxIf.gbx_seq), 64'(modelSeq));
    checkOutput("stall", 64'(gbxIf.tx_gbx_req_stall), 64'(modelSeq == 31));
    checkOutput("sync", 64'(gbxIf.tx_gbx_req_sync), 64'(modelSeq == 32));
    modelErr = 1'b0;
    if (modelSeq == 32) begin
      for (int i = 0; i < 64; i++)
        modelWord[i] = (modelBits.size() > 0) ? modelBits.pop_front() : 1'b0;
      modelBits.delete();
      modelValid = 1'b1;
      modelSeq   = 0;
      modelErr   = v;
    end else if (v) begin
      if (recordOn) sentBlocks.push_back(blkBits);
      for (int i = 0; i < 66; i++) modelBits.push_back(blkBits[i]);
      for (int i = 0; i < 64; i++) modelWord[i] = modelBits.pop_front();
      modelValid = 1'b1;
      modelSeq++;
    end else begin
      modelValid = 1'b0;
    end
    @(posedge clk);
    #1;
    lastWord  = gbxIf.serdes_tx_data;
    lastValid = gbxIf.serdes_tx_data_valid;
    checkOutput("valid", 64'(lastValid), 64'(modelValid));
    checkOutput("data", lastWord, modelWord);
    checkOutput("err", 64'(gbxIf.gbx_err), 64'(modelErr));
    if (recordOn && lastValid)
      for (int i = 0; i < 64; i++) rxBits.push_back(lastWord[i]);
  endtask

  task automatic doReset();
    rst = 1'b1;
    gbxIf.in_tx_valid = 1'b0;
    gbxIf.in_tx_data  = '0;
    gbxIf.in_tx_hdr   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelBits.delete();
    modelSeq   = 0;
    modelWord  = '0;
    modelValid = 1'b0;
    modelErr   = 1'b0;
    checkOutput("rstData", gbxIf.serdes_tx_data, 64'd0);
    checkOutput("rstValid", 64'(gbxIf.serdes_tx_data_valid), 64'd0);
    checkOutput("rstErr", 64'(gbxIf.gbx_err), 64'd0);
    checkOutput("rstSeq", 64'(gbxIf.gbx_seq), 64'd0);
    checkOutput("rstStall", 64'(gbxIf.tx_gbx_req_stall), 64'd0);
    checkOutput("rstSync", 64'(gbxIf.tx_gbx_req_sync), 64'd0);
  endtask

  function automatic logic [63:0] patData(input int n);
    return 64'hC0DE_0000_0000_0000 ^ (64'(n) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [1:0] patHdr(input int n);
    return (n % 3 == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    logic [63:0] words[33];
    logic [63:0] data0, data1, data31, rstData, wantWord;
    logic [65:0] gotBlk, expBlk;
    int          validCount;
    bit          prevStall, stallNow;
    int          n;

    rst = 1'b1;
    gbxIf.in_tx_valid = 1'b0;
    gbxIf.in_tx_data  = '0;
    gbxIf.in_tx_hdr   = '0;
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // Test 1: one full sequence with hand-derived word layouts.
    validCount = 0;
    for (int k = 0; k < 33; k++) begin
      if (k < 32) applyStimulus(1'b1, 64'hA5A5_0000_0000_0000 + 64'(k), 2'b01);
      else        applyStimulus(1'b0, 64'd0, 2'b00);
      words[k] = lastWord;
      if (lastValid) validCount++;
    end
    data0  = 64'hA5A5_0000_0000_0000;
    data1  = 64'hA5A5_0000_0000_0001;
    data31 = 64'hA5A5_0000_0000_001F;
    checkOutput("validCount", 64'(validCount), 64'd33);
    checkOutput("word0", words[0], {data0[61:0], 2'b01});
    checkOutput("word1", words[1], {data1[59:0], 2'b01, data0[63:62]});
    checkOutput("word31Hdr", 64'(words[31][63:62]), 64'(2'b01));
    // The final word of a sequence is the whole payload of block 31.
    checkOutput("word32", words[32], data31);
    checkOutput("seqWrap", 64'(gbxIf.gbx_seq), 64'd0);

    // Test 2: ten sequences with valid = ~registered(stall), then reassemble.
    doReset();
    recordOn  = 1'b1;
    prevStall = 1'b0;
    n = 0;
    for (int k = 0; k < 330; k++) begin
      stallNow = gbxIf.tx_gbx_req_stall;
      applyStimulus(!prevStall, patData(n), patHdr(n));
      checkOutput("contValid", 64'(lastValid), 64'd1);
      prevStall = stallNow;
      n++;
    end
    recordOn = 1'b0;
    checkOutput("reasmCount", 64'(sentBlocks.size()), 64'd320);
    checkOutput("reasmBits", 64'(rxBits.size()), 64'(320 * 66));
    while (sentBlocks.size() > 0 && rxBits.size() >= 66) begin
      expBlk = sentBlocks.pop_front();
      for (int i = 0; i < 66; i++) gotBlk[i] = rxBits.pop_front();
      checkOutput("reasmLo", gotBlk[63:0], expBlk[63:0]);
      checkOutput("reasmHi", 64'(gotBlk[65:64]), 64'(expBlk[65:64]));
    end

    // Test 3: block offered in the stall slot is dropped and flagged.
    doReset();
    for (int k = 0; k < 32; k++) applyStimulus(1'b1, patData(k + 500), patHdr(k));
    data31 = patData(531);
    applyStimulus(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 2'b10);
    checkOutput("dropErr", 64'(gbxIf.gbx_err), 64'd1);
    checkOutput("dropSeq", 64'(gbxIf.gbx_seq), 64'd0);
    checkOutput("dropResidue", lastWord, data31);
    rstData = patData(700);
    applyStimulus(1'b1, rstData, 2'b01);
    checkOutput("dropErrPulse", 64'(gbxIf.gbx_err), 64'd0);
    checkOutput("dropNextWord", lastWord, {rstData[61:0], 2'b01});
    for (int k = 1; k < 6; k++) applyStimulus(1'b1, patData(700 + k), patHdr(k));

    // Test 4: upstream gaps at seq 5 and seq 31.
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, patData(k + 900), patHdr(k));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, patData(999), 2'b01);
      checkOutput("gap5Valid", 64'(lastValid), 64'd0);
      checkOutput("gap5Seq", 64'(gbxIf.gbx_seq), 64'd5);
    end
    for (int k = 5; k < 31; k++) applyStimulus(1'b1, patData(k + 900), patHdr(k));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, patData(998), 2'b10);
      checkOutput("gap31Valid", 64'(lastValid), 64'd0);
      checkOutput("gap31Seq", 64'(gbxIf.gbx_seq), 64'd31);
      checkOutput("gap31Stall", 64'(gbxIf.tx_gbx_req_stall), 64'd1);
    end
    applyStimulus(1'b1, patData(931), patHdr(31));
    applyStimulus(1'b0, 64'd0, 2'b00);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, patData(k + 950), patHdr(k));

    // Test 5: reset mid-sequence discards the residue.
    doReset();
    for (int k = 0; k < 17; k++) applyStimulus(1'b1, patData(k + 1200), patHdr(k));
    checkOutput("preRstSeq", 64'(gbxIf.gbx_seq), 64'd17);
    doReset();
    rstData  = 64'h0123_4567_89AB_CDEF;
    wantWord = {rstData[61:0], 2'b10};
    applyStimulus(1'b1, rstData, 2'b10);
    checkOutput("postRstWord", lastWord, wantWord);
    checkOutput("postRstSeq", 64'(gbxIf.gbx_seq), 64'd1);
    applyStimulus(1'b0, 64'd0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
